// File: rtl/find_extreme.sv
// find_extreme: streaming extreme-value finder.
// Each accepted sample runs data_a/data_b through an 8-op functional unit.
// The block tracks the max or min result, the index of that result and the
// number of samples in the run.
// Optional macro FE_SUM_EN adds a running sum of the results on `sum`.
// When FE_SUM_EN is not defined, `sum` is tied to 0.
module find_extreme #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     valid,
    input  logic                     one_left,
    input  logic [2:0]               instruction,
    input  logic                     mode_min,
    input  logic                     signed_cmp,
    input  logic [DATA_W-1:0]        data_a,
    input  logic [DATA_W-1:0]        data_b,
    output logic [DATA_W-1:0]        extreme,
    output logic [CNT_W-1:0]         ext_index,
    output logic [CNT_W-1:0]         count,
    output logic [DATA_W+CNT_W-1:0]  sum,
    output logic                     busy,
    output logic                     overflow,
    output logic                     finish
);

    localparam int unsigned SUM_W = DATA_W + CNT_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_LAST = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   extreme_q, extreme_d;
    logic [CNT_W-1:0]    ext_index_q, ext_index_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                busy_q, busy_d;
    logic                overflow_q, overflow_d;
    logic                finish_q, finish_d;
    logic                mode_min_q, mode_min_d;
    logic                signed_q, signed_d;
    logic [DATA_W-1:0]   f_c;
    logic                better_c;
    logic                accept_c;
`ifdef FE_SUM_EN
    logic [SUM_W-1:0]    sum_q, sum_d;
`endif

    // Functional unit: combinational result, truncated to DATA_W
    always_comb begin
        f_c = '0;
        case (instruction)
            3'b000: f_c = data_a + data_b;
            3'b001: f_c = data_a + ~data_b;
            3'b010: f_c = data_a & data_b;
            3'b011: f_c = data_a | data_b;
            3'b100: f_c = data_a ^ data_b;
            3'b101: f_c = (data_a >> 1) + data_b;
            3'b110: f_c = {data_a[0], data_a[DATA_W-1:1]} + data_b;
            3'b111: f_c = {data_a[DATA_W-2:0], data_a[DATA_W-1]} + data_b;
            default: f_c = '0;
        endcase
    end

    // Strict improvement of f_c over the held extreme under latched mode/signedness
    always_comb begin
        better_c = 1'b0;
        if (signed_q) begin
            better_c = mode_min_q ? ($signed(f_c) < $signed(extreme_q))
                                  : ($signed(f_c) > $signed(extreme_q));
        end else begin
            better_c = mode_min_q ? (f_c < extreme_q) : (f_c > extreme_q);
        end
    end

    // Next-state and next-result logic; abort outranks every other control
    always_comb begin
        state_d     = state_q;
        extreme_d   = extreme_q;
        ext_index_d = ext_index_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        mode_min_d  = mode_min_q;
        signed_d    = signed_q;
        finish_d    = 1'b0;
        accept_c    = 1'b0;
`ifdef FE_SUM_EN
        sum_d       = sum_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (!abort && start) begin
                    state_d     = S_RUN;
                    extreme_d   = '0;
                    ext_index_d = '0;
                    count_d     = '0;
                    overflow_d  = 1'b0;
                    mode_min_d  = mode_min;
                    signed_d    = signed_cmp;
`ifdef FE_SUM_EN
                    sum_d       = '0;
`endif
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    accept_c = valid;
                    if (one_left) begin
                        state_d = S_LAST;
                    end
                end
            end
            S_LAST: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (valid) begin
                    accept_c = 1'b1;
                    state_d  = S_IDLE;
                    finish_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Sample update; once saturated, count_q already equals the top index
        if (accept_c) begin
            if (count_q == '0) begin
                extreme_d   = f_c;
                ext_index_d = '0;
            end else if (better_c) begin
                extreme_d   = f_c;
                ext_index_d = count_q;
            end
            if (count_q == CNT_MAX) begin
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
`ifdef FE_SUM_EN
            sum_d = sum_q + {{CNT_W{signed_q & f_c[DATA_W-1]}}, f_c};
`endif
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            extreme_q   <= '0;
            ext_index_q <= '0;
            count_q     <= '0;
            busy_q      <= 1'b0;
            overflow_q  <= 1'b0;
            finish_q    <= 1'b0;
            mode_min_q  <= 1'b0;
            signed_q    <= 1'b0;
`ifdef FE_SUM_EN
            sum_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            extreme_q   <= extreme_d;
            ext_index_q <= ext_index_d;
            count_q     <= count_d;
            busy_q      <= busy_d;
            overflow_q  <= overflow_d;
            finish_q    <= finish_d;
            mode_min_q  <= mode_min_d;
            signed_q    <= signed_d;
`ifdef FE_SUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    assign extreme   = extreme_q;
    assign ext_index = ext_index_q;
    assign count     = count_q;
    assign busy      = busy_q;
    assign overflow  = overflow_q;
    assign finish    = finish_q;
`ifdef FE_SUM_EN
    assign sum       = sum_q;
`else
    assign sum       = '0;
`endif

endmodule

// File: tb/tb_find_extreme.sv
// Testbench for find_extreme: a default instance and a CNT_W=2 instance share stimulus.
module tb_find_extreme;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort, valid, one_left, mode_min, signed_cmp;
    logic [2:0]  instruction;
    logic [7:0]  data_a, data_b;

    logic [7:0]  d_extreme;
    logic [7:0]  d_index, d_count;
    logic [15:0] d_sum;
    logic        d_busy, d_ovf, d_finish;

    logic [7:0]  s_extreme;
    logic [1:0]  s_index, s_count;
    logic [9:0]  s_sum;
    logic        s_busy, s_ovf, s_finish;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model state
    int f_list[$];
    int m_state;
    int m_finish;
    int m_min;
    int m_sgn;

    find_extreme #(.DATA_W(8), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .valid(valid),
        .one_left(one_left), .instruction(instruction), .mode_min(mode_min),
        .signed_cmp(signed_cmp), .data_a(data_a), .data_b(data_b),
        .extreme(d_extreme), .ext_index(d_index), .count(d_count), .sum(d_sum),
        .busy(d_busy), .overflow(d_ovf), .finish(d_finish)
    );

    find_extreme #(.DATA_W(8), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .valid(valid),
        .one_left(one_left), .instruction(instruction), .mode_min(mode_min),
        .signed_cmp(signed_cmp), .data_a(data_a), .data_b(data_b),
        .extreme(s_extreme), .ext_index(s_index), .count(s_count), .sum(s_sum),
        .busy(s_busy), .overflow(s_ovf), .finish(s_finish)
    );

    always #5 clk = ~clk;

    function automatic int ref_f(input int op, input int a, input int b);
        int r;
        case (op)
            0: r = a + b;
            1: r = a + (255 - b);
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = a / 2 + b;
            6: r = (a % 2) * 128 + a / 2 + b;
            default: r = (a * 2) % 256 + a / 128 + b;
        endcase
        return r % 256;
    endfunction

    function automatic int sval(input int x);
        return (m_sgn != 0 && x >= 128) ? x - 256 : x;
    endfunction

    function automatic int exp_best_idx();
        int bi = 0;
        for (int i = 1; i < f_list.size(); i++) begin
            if (m_min != 0 ? sval(f_list[i]) < sval(f_list[bi])
                           : sval(f_list[i]) > sval(f_list[bi]))
                bi = i;
        end
        return bi;
    endfunction

    function automatic int exp_sum(input int sw);
        int s = 0;
        int md = 1 << sw;
`ifdef FE_SUM_EN
        foreach (f_list[i]) s = (s + sval(f_list[i]) + md) % md;
`else
        s = md - md;
`endif
        return s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n = f_list.size();
        int bi = (n > 0) ? exp_best_idx() : 0;
        int ext = (n > 0) ? f_list[bi] : 0;
        chk({tag, ".extreme"},   32'(d_extreme), 32'(ext));
        chk({tag, ".index"},     32'(d_index),   32'((bi > 255) ? 255 : bi));
        chk({tag, ".count"},     32'(d_count),   32'((n > 255) ? 255 : n));
        chk({tag, ".overflow"},  32'(d_ovf),     32'(n > 255));
        chk({tag, ".busy"},      32'(d_busy),    32'(m_state != 0));
        chk({tag, ".finish"},    32'(d_finish),  32'(m_finish));
        chk({tag, ".sum"},       32'(d_sum),     32'(exp_sum(16)));
        chk({tag, ".s_extreme"}, 32'(s_extreme), 32'(ext));
        chk({tag, ".s_index"},   32'(s_index),   32'((bi > 3) ? 3 : bi));
        chk({tag, ".s_count"},   32'(s_count),   32'((n > 3) ? 3 : n));
        chk({tag, ".s_overflow"},32'(s_ovf),     32'(n > 3));
        chk({tag, ".s_busy"},    32'(s_busy),    32'(m_state != 0));
        chk({tag, ".s_finish"},  32'(s_finish),  32'(m_finish));
        chk({tag, ".s_sum"},     32'(s_sum),     32'(exp_sum(10)));
    endtask

    task automatic model_reset();
        f_list.delete();
        m_state = 0; m_finish = 0; m_min = 0; m_sgn = 0;
    endtask

    // one clock of stimulus, then model update and full check
    task automatic step(input string tag, input logic v, input logic ol, input logic ab,
                        input logic st, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic mn, input logic sg);
        valid = v; one_left = ol; abort = ab; start = st;
        instruction = op; data_a = a; data_b = b; mode_min = mn; signed_cmp = sg;
        @(posedge clk); #1;
        m_finish = 0;
        if (ab) begin
            m_state = 0;
        end else if (m_state == 0) begin
            if (st) begin
                f_list.delete(); m_min = int'(mn); m_sgn = int'(sg); m_state = 1;
            end
        end else if (m_state == 1) begin
            if (v) f_list.push_back(ref_f(int'(op), int'(a), int'(b)));
            if (ol) m_state = 2;
        end else if (v) begin
            f_list.push_back(ref_f(int'(op), int'(a), int'(b)));
            m_state = 0; m_finish = 1;
        end
        check_all(tag);
    endtask

    task automatic do_start(input string tag, input logic mn, input logic sg);
        step(tag, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 8'd0, 8'd0, mn, sg);
    endtask

    task automatic samp(input string tag, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic ol);
        step(tag, 1'b1, ol, 1'b0, 1'b0, op, a, b, 1'b0, 1'b0);
    endtask

    task automatic idle(input string tag, input logic ol);
        step(tag, 1'b0, ol, 1'b0, 1'b0, 3'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0] signed_vals [4];
        logic [7:0] ra, rb;
        logic [2:0] rop;
        int len;

        rst_n = 1'b0;
        start = 0; abort = 0; valid = 0; one_left = 0;
        mode_min = 0; signed_cmp = 0; instruction = '0; data_a = '0; data_b = '0;
        model_reset();
        @(posedge clk); #1;
        check_all("in_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle("after_reset", 1'b0);

        // unsigned max, opcode 000
        do_start("umax_start", 1'b0, 1'b0);
        samp("umax_s0", 3'd0, 8'd3, 8'd4, 1'b0);
        samp("umax_s1", 3'd0, 8'd10, 8'd5, 1'b0);
        samp("umax_s2", 3'd0, 8'd1, 8'd1, 1'b1);
        samp("umax_s3", 3'd0, 8'd2, 8'd2, 1'b0);
        chk("umax_const_extreme", 32'(d_extreme), 32'd15);
        idle("umax_hold", 1'b0);

        // signed min with ties, opcode 010 and A=B
        signed_vals[0] = 8'h05; signed_vals[1] = 8'h80;
        signed_vals[2] = 8'h7F; signed_vals[3] = 8'h80;
        do_start("smin_start", 1'b1, 1'b1);
        for (int i = 0; i < 4; i++)
            samp("smin_s", 3'd2, signed_vals[i], signed_vals[i], i == 2);
        chk("smin_const_index", 32'(d_index), 32'd1);

        // every opcode on a one-sample run
        for (int op = 0; op < 8; op++) begin
            do_start("op_start", 1'b0, 1'b0);
            idle("op_last", 1'b1);
            samp("op_sample", 3'(op), 8'h81, 8'h01, 1'b0);
        end

        // abort with valid, ignored controls
        do_start("ab_start", 1'b0, 1'b0);
        samp("ab_s0", 3'd0, 8'd5, 8'd5, 1'b0);
        samp("ab_s1", 3'd0, 8'd1, 8'd1, 1'b0);
        step("ab_abort", 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 8'd90, 8'd9, 1'b0, 1'b0);
        step("ab_idle_valid", 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd99, 8'd99, 1'b0, 1'b0);
        step("ab_abort_start", 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 8'd0, 8'd0, 1'b1, 1'b1);
        step("ab_start_valid", 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 8'd77, 8'd0, 1'b1, 1'b0);
        samp("ab_r0", 3'd4, 8'h30, 8'h03, 1'b0);
        step("ab_start_in_run", 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 8'd2, 8'd0, 1'b0, 1'b1);
        samp("ab_r2", 3'd0, 8'd4, 8'd0, 1'b1);
        step("ab_abort_last", 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 8'd1, 8'd0, 1'b0, 1'b0);

        // saturation of the CNT_W=2 instance with rising results
        do_start("sat_start", 1'b0, 1'b0);
        for (int i = 0; i < 6; i++)
            samp("sat_s", 3'd0, 8'(10 * (i + 1)), 8'd0, i == 4);
        chk("sat_const_count", 32'(s_count), 32'd3);

        // randomized runs against the model
        for (int r = 0; r < 12; r++) begin
            do_start("rnd_start", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            len = int'($urandom_range(1, 8));
            if (len == 1) idle("rnd_ol", 1'b1);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 3) == 0) idle("rnd_gap", 1'b0);
                rop = 3'($urandom_range(0, 7));
                ra = 8'($urandom); rb = 8'($urandom);
                samp("rnd_s", rop, ra, rb, k == len - 2);
            end
        end

        // wide unsigned samples, then asynchronous reset mid-run
        do_start("rst_start", 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) samp("rst_s", 3'd2, 8'hFF, 8'hFF, 1'b0);
`ifdef FE_SUM_EN
        chk("sum_const", 32'(d_sum), 32'h2FD);
`endif
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        #1 rst_n = 1'b1;
        idle("post_reset", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
